// File: rtl/vcm_i2c_slave.sv
`timescale 1ns/1ps
// vcm_i2c_slave: I2C target emulating a VCM driver holding one 16-bit position word.
// SCL/SDA are synchronized and glitch-filtered; all protocol decoding uses the filtered levels.
module vcm_i2c_slave #(
   parameter logic [6:0] DEV_ADDR = 7'h0C,
   parameter int         FILT     = 3
) (
   input  logic        CLK_50,
   input  logic        RESET,
   input  logic        SCL,
   inout  wire         SDA,
   output logic [15:0] VCM_DATA,
   output logic        WR_STB,
   output logic        BUSY,
   output logic [7:0]  WR_COUNT
);
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ADDR     = 3'd1;
   localparam logic [2:0] S_ADDR_ACK = 3'd2;
   localparam logic [2:0] S_WR_BYTE  = 3'd3;
   localparam logic [2:0] S_WR_ACK   = 3'd4;
   localparam logic [2:0] S_RD_BYTE  = 3'd5;
   localparam logic [2:0] S_RD_ACK   = 3'd6;
   localparam int         CW         = (FILT > 1) ? $clog2(FILT) : 1;

   logic [1:0] raw, flt;
   assign raw = {SDA, SCL};

   // A level change is accepted only after FILT consecutive differing samples.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_flt
         logic          s1_q, s2_q, lvl_q;
         logic [CW-1:0] cnt_q;
         always_ff @(posedge CLK_50 or posedge RESET) begin
            if (RESET) begin
               s1_q  <= 1'b1;
               s2_q  <= 1'b1;
               lvl_q <= 1'b1;
               cnt_q <= '0;
            end else begin
               s1_q <= raw[gi];
               s2_q <= s1_q;
               if (s2_q == lvl_q) begin
                  cnt_q <= '0;
               end else if (cnt_q == CW'(FILT - 1)) begin
                  lvl_q <= s2_q;
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         end
         assign flt[gi] = lvl_q;
      end
   endgenerate

   logic        scl_f, sda_f, scl_p_q, sda_p_q;
   logic        scl_rise, scl_fall, start_det, stop_det;
   logic [2:0]  state_q, state_d, bit_cnt_q, bit_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [6:0]  shift_q, shift_d, tx_q, tx_d;
   logic [7:0]  shift_in, rd_byte, shadow_q, shadow_d, wr_cnt_q, wr_cnt_d;
   logic        phase_q, phase_d, rw_q, rw_d, sda_low_q, sda_low_d;
   logic        busy_q, busy_d, wr_stb_q, wr_stb_d;
   logic [15:0] vcm_q, vcm_d;

   assign scl_f     = flt[0];
   assign sda_f     = flt[1];
   assign scl_rise  = scl_f & ~scl_p_q;
   assign scl_fall  = ~scl_f & scl_p_q;
   assign start_det = scl_f & scl_p_q & sda_p_q & ~sda_f;
   assign stop_det  = scl_f & scl_p_q & ~sda_p_q & sda_f;
   assign shift_in  = {shift_q, sda_f};
   assign rd_byte   = (byte_cnt_q == 2'd0) ? vcm_q[15:8] :
                      (byte_cnt_q == 2'd1) ? vcm_q[7:0] : 8'hFF;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      shadow_d   = shadow_q;
      phase_d    = phase_q;
      rw_d       = rw_q;
      sda_low_d  = sda_low_q;
      busy_d     = busy_q;
      vcm_d      = vcm_q;
      wr_cnt_d   = wr_cnt_q;
      wr_stb_d   = 1'b0;
      if (start_det) begin
         state_d    = S_ADDR;
         sda_low_d  = 1'b0;
         bit_cnt_d  = 3'd0;
         byte_cnt_d = 2'd0;
         phase_d    = 1'b0;
      end else if (stop_det) begin
         state_d   = S_IDLE;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
         phase_d   = 1'b0;
      end else begin
         case (state_q)
            S_ADDR: if (scl_rise) begin
               shift_d   = shift_in[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (shift_in[7:1] == DEV_ADDR) begin
                     state_d = S_ADDR_ACK;
                     busy_d  = 1'b1;
                     rw_d    = shift_in[0];
                  end else begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                  end
               end
            end
            // Ack states: first falling edge pulls SDA low, second ends the ninth clock.
            S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
               if (!phase_q) begin
                  sda_low_d = 1'b1;
                  phase_d   = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (state_q == S_ADDR_ACK && rw_q) begin
                     state_d   = S_RD_BYTE;
                     tx_d      = rd_byte[6:0];
                     sda_low_d = ~rd_byte[7];
                  end else begin
                     state_d   = S_WR_BYTE;
                     sda_low_d = 1'b0;
                  end
               end
            end
            S_WR_BYTE: if (scl_rise) begin
               shift_d   = shift_in[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (byte_cnt_q == 2'd2) begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                  end else begin
                     state_d    = S_WR_ACK;
                     byte_cnt_d = byte_cnt_q + 2'd1;
                     if (byte_cnt_q == 2'd0) begin
                        shadow_d = shift_in;
                     end else begin
                        vcm_d    = {shadow_q, shift_in};
                        wr_stb_d = 1'b1;
                        wr_cnt_d = wr_cnt_q + 8'd1;
                     end
                  end
               end
            end
            S_RD_BYTE: if (scl_rise) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_RD_ACK;
                  if (byte_cnt_q != 2'd2) byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end else if (scl_fall) begin
               sda_low_d = ~tx_q[6];
               tx_d      = {tx_q[5:0], 1'b1};
            end
            S_RD_ACK: if (scl_fall) begin
               if (!phase_q) begin
                  sda_low_d = 1'b0;
                  phase_d   = 1'b1;
               end else begin
                  state_d   = S_RD_BYTE;
                  phase_d   = 1'b0;
                  tx_d      = rd_byte[6:0];
                  sda_low_d = ~rd_byte[7];
               end
            end else if (scl_rise && phase_q && sda_f) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               phase_d = 1'b0;
            end
            default: begin
               state_d   = S_IDLE;
               sda_low_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK_50 or posedge RESET) begin
      if (RESET) begin
         scl_p_q    <= 1'b1;
         sda_p_q    <= 1'b1;
         state_q    <= S_IDLE;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 2'd0;
         shift_q    <= 7'd0;
         tx_q       <= 7'h7F;
         shadow_q   <= 8'd0;
         phase_q    <= 1'b0;
         rw_q       <= 1'b0;
         sda_low_q  <= 1'b0;
         busy_q     <= 1'b0;
         vcm_q      <= 16'h0000;
         wr_cnt_q   <= 8'h00;
         wr_stb_q   <= 1'b0;
      end else begin
         scl_p_q    <= scl_f;
         sda_p_q    <= sda_f;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         shadow_q   <= shadow_d;
         phase_q    <= phase_d;
         rw_q       <= rw_d;
         sda_low_q  <= sda_low_d;
         busy_q     <= busy_d;
         vcm_q      <= vcm_d;
         wr_cnt_q   <= wr_cnt_d;
         wr_stb_q   <= wr_stb_d;
      end
   end

   assign SDA      = sda_low_q ? 1'b0 : 1'bz;
   assign VCM_DATA = vcm_q;
   assign WR_STB   = wr_stb_q;
   assign BUSY     = busy_q;
   assign WR_COUNT = wr_cnt_q;
endmodule

// File: tb/tb_vcm_i2c_slave.sv
`timescale 1ns/1ps
// Bench for vcm_i2c_slave: a bit-banged bus master drives directed and random transactions;
// a word-level model of the VCM register predicts acks, read bytes, VCM_DATA and WR_COUNT.
module tb_vcm_i2c_slave;
   localparam int         H   = 16;
   localparam logic [6:0] DEV = 7'h0C;

   logic        clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
   wire         sda_bus;
   logic [15:0] vcm;
   logic        wr_stb, busy;
   logic [7:0]  wr_count;

   pullup (sda_bus);
   assign sda_bus = m_low ? 1'b0 : 1'bz;

   vcm_i2c_slave #(.DEV_ADDR(DEV), .FILT(3)) dut (
      .CLK_50(clk), .RESET(rst), .SCL(scl), .SDA(sda_bus),
      .VCM_DATA(vcm), .WR_STB(wr_stb), .BUSY(busy), .WR_COUNT(wr_count));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int stb_pulses = 0, stb_long = 0;
   bit stb_prev = 1'b0, dut_low_seen = 1'b0;

   // Reference model state
   logic [15:0] m_vcm = 16'h0000;
   logic [7:0]  m_cnt = 8'h00;
   int          m_stb = 0;
   logic [7:0]  wbuf [4];

   always @(negedge clk) begin
      if (wr_stb && !stb_prev) stb_pulses++;
      if (wr_stb && stb_prev) stb_long++;
      stb_prev = wr_stb;
      if (!m_low && sda_bus === 1'b0) dut_low_seen = 1'b1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic i2c_start();
      m_low = 1'b0;
      wait_clk(H/2);
      if (!scl) begin
         scl = 1'b1;
         wait_clk(H/2);
      end
      m_low = 1'b1;
      wait_clk(H/2);
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(H/2); m_low = 1'b1;
      wait_clk(H/2); scl = 1'b1;
      wait_clk(H);   m_low = 1'b0;
      wait_clk(H);
   endtask

   task automatic send_bit(input bit b);
      wait_clk(H/2); m_low = !b;
      wait_clk(H/2); scl = 1'b1;
      wait_clk(H);   scl = 1'b0;
   endtask

   task automatic recv_bit(output bit b);
      wait_clk(H/2); m_low = 1'b0;
      wait_clk(H/2); scl = 1'b1;
      wait_clk(H/2);
      @(negedge clk) b = sda_bus;
      wait_clk(H/2); scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, output bit ack);
      bit nack;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(nack);
      ack = !nack;
   endtask

   task automatic recv_byte(input bit ack, output logic [7:0] d);
      bit b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(!ack);
   endtask

   // One transaction; reads use wbuf only when the address does not match.
   task automatic xfer(input logic [6:0] addr, input bit rd, input int n, input bit end_sr);
      bit         ack;
      bit         match;
      logic [7:0] d, exp_b;
      match = (addr == DEV);
      i2c_start();
      send_byte({addr, rd}, ack);
      check_val("addr_ack", ack, match);
      check_val("busy_addr", busy, match);
      for (int i = 0; i < n; i++) begin
         if (rd && match) begin
            recv_byte(i < n - 1, d);
            exp_b = (i == 0) ? m_vcm[15:8] : (i == 1) ? m_vcm[7:0] : 8'hFF;
            check_val("rd_byte", d, exp_b);
         end else begin
            send_byte(wbuf[i], ack);
            check_val("wr_ack", ack, match && i < 2);
         end
      end
      if (rd && match) begin
         check_val("rd_release", sda_bus, 1'b1);
         check_val("busy_nack", busy, 1'b0);
      end
      if (!rd && match && n >= 2) begin
         m_vcm = {wbuf[0], wbuf[1]};
         m_cnt = m_cnt + 8'd1;
         m_stb++;
      end
      if (!end_sr) begin
         i2c_stop();
         check_val("busy_idle", busy, 1'b0);
      end
      wait_clk(4);
      check_val("vcm_data", vcm, m_vcm);
      check_val("wr_count", wr_count, m_cnt);
      check_val("wr_stb_pulses", stb_pulses, m_stb);
   endtask

   initial begin
      #900000;
      checks++;
      errors++;
      $display("FAIL watchdog: observed timeout, expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      logic [7:0] a;
      logic [6:0] ra;
      bit         rrd;
      int         rn, t;

      wait_clk(5);
      check_val("rst_vcm", vcm, 16'h0000);
      check_val("rst_stb", wr_stb, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_count", wr_count, 8'h00);
      check_val("rst_sda", sda_bus, 1'b1);
      rst = 1'b0;
      wait_clk(H);

      // Basic two-byte write
      wbuf[0] = 8'h03; wbuf[1] = 8'hF0;
      xfer(DEV, 1'b0, 2, 1'b0);
      check_val("write_word", vcm, 16'h03F0);

      // Wrong address: bus must never be pulled low by the target
      dut_low_seen = 1'b0;
      wbuf[0] = 8'h12; wbuf[1] = 8'h34;
      xfer(7'h0D, 1'b0, 2, 1'b0);
      check_val("wrong_addr_sda", dut_low_seen, 1'b0);

      // Read back both bytes
      xfer(DEV, 1'b1, 2, 1'b0);

      // Truncated write then repeated START into a one-byte read
      wbuf[0] = 8'hAA;
      xfer(DEV, 1'b0, 1, 1'b1);
      xfer(DEV, 1'b1, 1, 1'b0);
      check_val("trunc_vcm", vcm, 16'h03F0);

      // Third write byte is refused
      wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
      xfer(DEV, 1'b0, 3, 1'b0);
      check_val("third_byte_vcm", vcm, 16'h0102);

      // Reset while the target holds the address ACK
      a = {DEV, 1'b0};
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(a[i]);
      m_low = 1'b0;
      t = 0;
      while (sda_bus !== 1'b0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      check_val("ack_before_rst", sda_bus, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("rst_sda_release", sda_bus, 1'b1);
      check_val("rst_vcm_mid", vcm, 16'h0000);
      check_val("rst_busy_mid", busy, 1'b0);
      check_val("rst_count_mid", wr_count, 8'h00);
      m_vcm = 16'h0000;
      m_cnt = 8'h00;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H);
      wbuf[0] = 8'h55; wbuf[1] = 8'hAA;
      xfer(DEV, 1'b0, 2, 1'b0);

      // Random traffic
      for (int k = 0; k < 16; k++) begin
         ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DEV;
         if (k % 5 == 4 && ra == DEV) ra = DEV ^ 7'h01;
         rrd = 1'($urandom_range(0, 1));
         rn  = rrd ? $urandom_range(1, 3) : $urandom_range(0, 4);
         for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
         xfer(ra, rrd, rn, (k < 15) ? 1'($urandom_range(0, 1)) : 1'b0);
      end

      check_val("wr_stb_width", stb_long, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vcm_i2c_slave.md
VCM_I2C_SLAVE -- requirements
Module: vcm_i2c_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h0C: 7-bit I2C target address of the emulated VCM driver.
REQ-002 SHALL have parameter FILT, default 3: number of consecutive equal synchronized samples required before an SCL/SDA level change is accepted.
REQ-003 SHALL have port CLK_50, input, 1 bit: the single clock for all logic; rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port SCL, input, 1 bit: I2C clock from the bus master; asynchronous to CLK_50.
REQ-006 SHALL have port SDA, inout, 1 bit: I2C data; open-drain, driven only as 0 or high-Z.
REQ-007 SHALL have port VCM_DATA, output, 16 bits: last committed two-byte VCM word, MSB byte first on the bus.
REQ-008 SHALL have port WR_STB, output, 1 bit: one-cycle pulse when VCM_DATA is updated.
REQ-009 SHALL have port BUSY, output, 1 bit: high while an addressed transaction is in progress.
REQ-010 SHALL have port WR_COUNT, output, 8 bits: number of committed writes, wrapping 8'hFF to 8'h00.

Function
REQ-011 SHALL pass SCL and SDA through a 2-flop synchronizer and then a FILT-sample glitch filter; all decoding SHALL use the filtered levels only.
REQ-012 SHALL detect START as filtered SDA 1->0 while filtered SCL is high, and STOP as filtered SDA 0->1 while filtered SCL is high.
REQ-013 SHALL sample SDA on a filtered SCL rising edge and change its own SDA drive only on a filtered SCL falling edge.
REQ-014 SHALL implement the states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
REQ-015 IDLE -> ADDR on START; in ADDR it SHALL shift in 8 bits, MSB first (7 address bits, then R/W).
REQ-016 On address match it SHALL pull SDA low for the 9th clock (ADDR_ACK), set BUSY, and go to WR_BYTE if R/W=0 or RD_BYTE if R/W=1.
REQ-017 On address mismatch it SHALL leave SDA released, keep BUSY low, and go to IDLE, ignoring the bus until the next START.
REQ-018 In WR_BYTE it SHALL shift 8 bits into a 16-bit shadow register: byte 0 -> shadow[15:8], byte 1 -> shadow[7:0]; each byte 0 and byte 1 SHALL be ACKed in WR_ACK.
REQ-019 One CLK_50 cycle after the filtered SCL rising edge of bit 8 of byte 1, it SHALL load VCM_DATA from the shadow register, pulse WR_STB high for exactly one cycle, and increment WR_COUNT.
REQ-020 A third or later write byte SHALL be NACKed (SDA released) and the state SHALL go to IDLE; VCM_DATA SHALL be unaffected.
REQ-021 A write ended by STOP or START after 0 or 1 complete data bytes SHALL NOT change VCM_DATA, WR_STB or WR_COUNT.
REQ-022 In RD_BYTE it SHALL drive VCM_DATA[15:8] for byte 0, VCM_DATA[7:0] for byte 1, and 8'hFF for any later byte; the byte value SHALL be captured at the start of each byte.
REQ-023 In RD_ACK, master ACK (SDA=0) SHALL continue with the next byte; master NACK SHALL release SDA and go to IDLE.
REQ-024 A START in any state, including a repeated START, SHALL release SDA, clear the bit and byte counters, and go to ADDR.
REQ-025 A STOP in any state SHALL release SDA, clear BUSY and go to IDLE.
REQ-026 SDA SHALL never be driven while the state is IDLE or ADDR.
REQ-027 WR_STB and a START/STOP SHALL never coincide; if a STOP occurs in the commit cycle, the commit SHALL still complete.

Reset
REQ-028 While RESET=1, SDA SHALL be released immediately (asynchronously), the state SHALL be IDLE, VCM_DATA=16'h0000, WR_STB=0, BUSY=0, WR_COUNT=8'h00, and the synchronizers and filters SHALL be set to 1.
REQ-029 After RESET deasserts mid-transaction, the block SHALL ignore bus activity until the next START.

Verification
REQ-030 Write: START, 0x18 (0x0C+W), 0x03, 0xF0, STOP -> three ACKs; VCM_DATA=16'h03F0; one WR_STB pulse; WR_COUNT=1.
REQ-031 Wrong address: START, 0x1A, 0x12, 0x34, STOP -> SDA never driven low; VCM_DATA, WR_STB and BUSY unchanged.
REQ-032 Read after REQ-030: START, 0x19, read 2 bytes (ACK, then NACK), STOP -> bytes 0x03, 0xF0 are returned; SDA is released after the NACK.
REQ-033 Truncated write then repeated START: 0x18, 0xAA, Sr, 0x19, read 1 byte -> VCM_DATA unchanged; byte 0x03 is returned.
REQ-034 Third byte: 0x18, 0x01, 0x02, 0x03 -> 0x03 is NACKed; VCM_DATA=16'h0102; exactly one WR_STB pulse.
REQ-035 RESET asserted while driving the ACK after the address -> SDA goes high-Z in the same cycle; VCM_DATA=0; BUSY=0; a subsequent full write succeeds.
